// File: rtl/teclado_captura.sv
// Keypad consumer: debounces the scanner code, emits one action per press and builds a BCD operand.
// Optional macro TECLADO_RETROCESO_EN turns key 14 from clear into backspace.
module teclado_captura #(
    parameter int NDIG    = 4,
    parameter int DEB_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        posicion,
    input  logic              opr,
    output logic [4*NDIG-1:0] operando,
    output logic [3:0]        num_dig,
    output logic [1:0]        op_code,
    output logic              op_stb,
    output logic              ent_stb,
    output logic              ovf
);

    localparam int             CW      = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEB_CYC);
    localparam logic [3:0]     NDIG_L  = 4'(NDIG);

    typedef enum logic [2:0] {IDLE, DEB_ON, PRESS, WAIT_REL, DEB_OFF} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [3:0]        k_reg, k_nxt;
    logic              do_dig, do_op, do_clr, do_ent;
    logic [4*NDIG-1:0] opd_push;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            k_reg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            k_reg <= k_nxt;
        end
    end

    // NOTE: defaults first in every combinational block so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        k_nxt     = k_reg;
        case (state)
            IDLE: if (opr) begin
                state_nxt = DEB_ON;
                k_nxt     = posicion;
                cnt_nxt   = CW'(1);
            end
            DEB_ON: begin
                if (!opr) begin
                    state_nxt = IDLE;
                end else if (posicion != k_reg) begin
                    k_nxt   = posicion;
                    cnt_nxt = CW'(1);
                end else if (cnt == CNT_MAX) begin
                    state_nxt = PRESS;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESS: state_nxt = WAIT_REL;
            WAIT_REL: if (!opr) begin
                state_nxt = DEB_OFF;
                cnt_nxt   = CW'(1);
            end
            DEB_OFF: begin
                if (opr) begin
                    state_nxt = WAIT_REL;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        do_dig = (state == PRESS) && (k_reg <= 4'd9);
        do_op  = (state == PRESS) && (k_reg >= 4'd10) && (k_reg <= 4'd13);
        do_clr = (state == PRESS) && (k_reg == 4'd14);
        do_ent = (state == PRESS) && (k_reg == 4'd15);
        opd_push      = operando << 4;
        opd_push[3:0] = k_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            operando <= '0;
            num_dig  <= '0;
            op_code  <= '0;
            op_stb   <= 1'b0;
            ent_stb  <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            op_stb  <= do_op;
            ent_stb <= do_ent;
            // Adding 2 mod 4 maps keys 10..13 onto operator codes 0..3.
            if (do_op)
                op_code <= k_reg[1:0] + 2'd2;
            if (do_dig) begin
                if (num_dig == NDIG_L) begin
                    ovf <= 1'b1;
                end else begin
                    operando <= opd_push;
                    num_dig  <= num_dig + 4'd1;
                end
            end
            if (do_clr) begin
`ifdef TECLADO_RETROCESO_EN
                if (num_dig != 4'd0) begin
                    operando <= operando >> 4;
                    num_dig  <= num_dig - 4'd1;
                    ovf      <= 1'b0;
                end
`else
                operando <= '0;
                num_dig  <= '0;
                ovf      <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_teclado_captura.sv
// Bench for teclado_captura: table of key presses with expected operand state, plus a strobe scoreboard.
module tb_teclado_captura;

    localparam int NDIG    = 4;
    localparam int DEB_CYC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  posicion;
    logic        opr;
    logic [15:0] operando;
    logic [3:0]  num_dig;
    logic [1:0]  op_code;
    logic        op_stb;
    logic        ent_stb;
    logic        ovf;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0]  key;
        int          hold;
        logic [15:0] opd;
        logic [3:0]  num;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic       is_op;
        logic [1:0] code;
    } stb_t;

    vec_t vecs[$];
    stb_t stb_q[$];

    teclado_captura #(.NDIG(NDIG), .DEB_CYC(DEB_CYC)) dut (
        .clk(clk), .rst(rst), .posicion(posicion), .opr(opr),
        .operando(operando), .num_dig(num_dig), .op_code(op_code),
        .op_stb(op_stb), .ent_stb(ent_stb), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] key, input logic [15:0] opd,
                                input logic [3:0] num, input logic ov);
        vec_t v;
        v.key = key; v.hold = 10; v.opd = opd; v.num = num; v.ovf = ov;
        return v;
    endfunction

    // Scoreboard consumer: every strobe seen must match the oldest expected one.
    always @(negedge clk) begin
        if (op_stb || ent_stb) begin
            stb_t e;
            check("strobe_exclusive", {31'd0, op_stb && ent_stb}, 32'd0);
            if (stb_q.size() == 0) begin
                check("unexpected_strobe", {30'd0, op_stb, ent_stb}, 32'd0);
            end else begin
                e = stb_q.pop_front();
                check("strobe_kind", {31'd0, op_stb}, {31'd0, e.is_op});
                if (e.is_op)
                    check("op_code", {30'd0, op_code}, {30'd0, e.code});
            end
        end
    end

    task automatic press_key(input logic [3:0] k, input int hold, input int rel);
        stb_t s;
        @(negedge clk);
        opr = 1'b1;
        posicion = k;
        if (k >= 4'd10 && k <= 4'd13) begin
            s.is_op = 1'b1; s.code = 2'(k - 4'd10); stb_q.push_back(s);
        end else if (k == 4'd15) begin
            s.is_op = 1'b0; s.code = 2'd0; stb_q.push_back(s);
        end
        repeat (hold) @(negedge clk);
        opr = 1'b0;
        repeat (rel) @(negedge clk);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            press_key(vecs[i].key, vecs[i].hold, 8);
            check($sformatf("row%0d_operando", i), {16'd0, operando}, {16'd0, vecs[i].opd});
            check($sformatf("row%0d_num_dig", i), {28'd0, num_dig}, {28'd0, vecs[i].num});
            check($sformatf("row%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].ovf});
        end
    endtask

    // Starts a press from IDLE and checks the action lands exactly DEB_CYC+1 edges later.
    task automatic latency_press(input logic [3:0] k, input string tag);
        @(negedge clk);
        opr = 1'b1;
        posicion = k;
        repeat (DEB_CYC + 1) @(negedge clk);
        check({tag, "_before"}, {28'd0, num_dig}, 32'd0);
        @(negedge clk);
        check({tag, "_after"}, {28'd0, num_dig}, 32'd1);
        check({tag, "_operando"}, {16'd0, operando}, {28'd0, k});
    endtask

    initial begin
        // Part A rows 0..15
        vecs.push_back(mk(4'd7,  16'h0007, 4'd1, 1'b0));
        vecs.push_back(mk(4'd14, 16'h0000, 4'd0, 1'b0));
        vecs.push_back(mk(4'd1,  16'h0001, 4'd1, 1'b0));
        vecs.push_back(mk(4'd2,  16'h0012, 4'd2, 1'b0));
        vecs.push_back(mk(4'd3,  16'h0123, 4'd3, 1'b0));
        vecs.push_back(mk(4'd4,  16'h1234, 4'd4, 1'b0));
        vecs.push_back(mk(4'd5,  16'h1234, 4'd4, 1'b1));
        vecs.push_back(mk(4'd12, 16'h1234, 4'd4, 1'b1));
        vecs.push_back(mk(4'd15, 16'h1234, 4'd4, 1'b1));
        vecs.push_back(mk(4'd10, 16'h1234, 4'd4, 1'b1));
        vecs.push_back(mk(4'd13, 16'h1234, 4'd4, 1'b1));
`ifdef TECLADO_RETROCESO_EN
        vecs.push_back(mk(4'd14, 16'h0123, 4'd3, 1'b0));
        vecs.push_back(mk(4'd14, 16'h0012, 4'd2, 1'b0));
        vecs.push_back(mk(4'd14, 16'h0001, 4'd1, 1'b0));
        vecs.push_back(mk(4'd14, 16'h0000, 4'd0, 1'b0));
        vecs.push_back(mk(4'd14, 16'h0000, 4'd0, 1'b0));
`else
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(4'd14, 16'h0000, 4'd0, 1'b0));
`endif
        // Part B rows 16..20
        vecs.push_back(mk(4'd14, 16'h0000, 4'd0, 1'b0));
        vecs.push_back(mk(4'd4,  16'h0004, 4'd1, 1'b0));
        vecs.push_back(mk(4'd5,  16'h0045, 4'd2, 1'b0));
`ifdef TECLADO_RETROCESO_EN
        vecs.push_back(mk(4'd14, 16'h0004, 4'd1, 1'b0));
        vecs.push_back(mk(4'd8,  16'h0048, 4'd2, 1'b0));
`else
        vecs.push_back(mk(4'd14, 16'h0000, 4'd0, 1'b0));
        vecs.push_back(mk(4'd8,  16'h0008, 4'd1, 1'b0));
`endif

        rst = 1'b1;
        opr = 1'b0;
        posicion = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_operando", {16'd0, operando}, 32'd0);
        check("rst_num_dig", {28'd0, num_dig}, 32'd0);
        check("rst_op_code", {30'd0, op_code}, 32'd0);
        check("rst_op_stb", {31'd0, op_stb}, 32'd0);
        check("rst_ent_stb", {31'd0, ent_stb}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0;

        run_rows(0, 15);

        // Press shorter than the debounce window must be ignored.
        @(negedge clk);
        opr = 1'b1;
        posicion = 4'd5;
        repeat (2) @(negedge clk);
        opr = 1'b0;
        repeat (8) @(negedge clk);
        check("glitch_operando", {16'd0, operando}, 32'd0);
        check("glitch_num_dig", {28'd0, num_dig}, 32'd0);

        // Long hold with a short release glitch enters one digit only.
        latency_press(4'd3, "hold3");
        repeat (14) @(negedge clk);
        opr = 1'b0;
        repeat (2) @(negedge clk);
        opr = 1'b1;
        repeat (18) @(negedge clk);
        opr = 1'b0;
        repeat (8) @(negedge clk);
        check("hold3_final_operando", {16'd0, operando}, 32'h0003);
        check("hold3_final_num_dig", {28'd0, num_dig}, 32'd1);

        run_rows(16, 20);

        // Reset while debouncing a new key.
        @(negedge clk);
        opr = 1'b1;
        posicion = 4'd6;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        opr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_operando", {16'd0, operando}, 32'd0);
        check("midrst_num_dig", {28'd0, num_dig}, 32'd0);
        check("midrst_op_code", {30'd0, op_code}, 32'd0);
        check("midrst_ovf", {31'd0, ovf}, 32'd0);
        repeat (3) @(negedge clk);
        latency_press(4'd9, "post_rst");
        opr = 1'b0;
        repeat (8) @(negedge clk);

        check("strobe_queue_drained", stb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
